// File: rtl/dsi_lane_scheduler_if.sv
// Bundles the requester-side and PHY-side signals of dsi_lane_scheduler.
//   slave  : the scheduler side (takes requests, drives the PHY byte/LP lanes)
//   master : the requester/PHY-model side (drives requests, observes lanes)
// Signals:
//   vid_req, vid_valid, vid_data[7:0], vid_last, vid_ready : video line burst
//   cmd_valid, cmd_pkt[31:0] {ECC,data1,data0,DI}, cmd_ready : short packet
//   byte_D0[7:0], hs_data_en, hs_clk_en                  : HS lane controls
//   lp_data[1:0], lp_clk[1:0] ({P,N})                     : LP lane levels
//   underrun                                              : sticky starvation
interface dsi_lane_scheduler_if;
    logic        vid_req;
    logic        vid_valid;
    logic [7:0]  vid_data;
    logic        vid_last;
    logic        vid_ready;
    logic        cmd_valid;
    logic [31:0] cmd_pkt;
    logic        cmd_ready;
    logic [7:0]  byte_D0;
    logic        hs_data_en;
    logic        hs_clk_en;
    logic [1:0]  lp_data;
    logic [1:0]  lp_clk;
    logic        underrun;

    modport slave (
        input  vid_req, vid_valid, vid_data, vid_last, cmd_valid, cmd_pkt,
        output vid_ready, cmd_ready, byte_D0, hs_data_en, hs_clk_en, lp_data, lp_clk,
               underrun
    );

    modport master (
        output vid_req, vid_valid, vid_data, vid_last, cmd_valid, cmd_pkt,
        input  vid_ready, cmd_ready, byte_D0, hs_data_en, hs_clk_en, lp_data, lp_clk,
               underrun
    );
endinterface

// File: rtl/dsi_lane_scheduler.sv
// DSI single-lane burst scheduler: arbitrates between a video line burst and a
// 4-byte short command packet, then walks the data lane through the LP->HS entry
// (LPX, PREP, ZERO, SYNC), the payload, optional EoTp, HS-trail and LP exit.
// Ports:
//   i_byte_clk : sole clock
//   i_reset    : synchronous, active-high reset
//   io_bus     : dsi_lane_scheduler_if.slave (request handshakes + lane outputs)
// Configuration macro:
//   DSI_SCHED_EOTP_EN : when defined, a 4-byte EoT packet (08 0F 0F 01) follows
//                       the payload; otherwise the EOT state logic is absent.
module dsi_lane_scheduler #(
    parameter int unsigned T_LPX   = 2,
    parameter int unsigned T_PREP  = 2,
    parameter int unsigned T_ZERO  = 4,
    parameter int unsigned T_TRAIL = 3
) (
    input  logic                i_byte_clk,
    input  logic                i_reset,
    dsi_lane_scheduler_if.slave io_bus
);
    // Counter load values; a zero duration is stretched to a single cycle.
    localparam logic [7:0] LPX_LD   = (T_LPX   == 0) ? 8'd0 : 8'(T_LPX - 1);
    localparam logic [7:0] PREP_LD  = (T_PREP  == 0) ? 8'd0 : 8'(T_PREP - 1);
    localparam logic [7:0] ZERO_LD  = (T_ZERO  == 0) ? 8'd0 : 8'(T_ZERO - 1);
    localparam logic [7:0] TRAIL_LD = (T_TRAIL == 0) ? 8'd0 : 8'(T_TRAIL - 1);

    typedef enum logic [3:0] {
        StIdle, StLpx, StPrep, StZero, StSync, StPayload, StEot, StTrail, StExit
    } state_e;

    state_e      r_state, w_state_d;
    logic [7:0]  r_cnt, w_cnt_d;
    logic        r_grant_vid;
    logic        r_last_vid;
    logic [31:0] r_cmd;
    logic [7:0]  r_last_byte, w_last_byte_d;
    logic [7:0]  r_byte, w_byte_d;
    logic [1:0]  r_lp_data, w_lp_data_d;
    logic [1:0]  r_lp_clk, w_lp_clk_d;
    logic        r_hs_data_en, w_hs_data_en_d;
    logic        r_hs_clk_en, w_hs_clk_en_d;
    logic        r_vid_ready, w_vid_ready_d;
    logic        r_underrun;
    logic        w_grant_cmd, w_grant_vid, w_vid_phase, w_payload_done;
    logic [7:0]  w_byte_out;

    // Round robin: cmd wins a tie unless it was the last one served.
    assign w_grant_cmd = io_bus.cmd_valid & (~io_bus.vid_req | r_last_vid);
    assign w_grant_vid = io_bus.vid_req & ~w_grant_cmd;
    assign w_vid_phase = (r_state == StPayload) & r_grant_vid;

    // Video bytes are accepted and forwarded in the same cycle; every other byte
    // comes straight from r_byte, which is loaded on entry to its state.
    assign w_byte_out    = w_vid_phase ? (io_bus.vid_valid ? io_bus.vid_data : 8'h00) : r_byte;
    assign w_last_byte_d = (r_state == StPayload || r_state == StEot) ? w_byte_out
                                                                      : r_last_byte;
    assign w_payload_done = r_grant_vid ? (io_bus.vid_valid & io_bus.vid_last)
                                        : (r_cnt == 8'd0);

    // Next state and phase counter.
    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_grant_cmd | w_grant_vid) begin
                    w_state_d = StLpx;
                    w_cnt_d   = LPX_LD;
                end
            end
            StLpx: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StPrep;
                    w_cnt_d   = PREP_LD;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StPrep: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StZero;
                    w_cnt_d   = ZERO_LD;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StZero: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StSync;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StSync: begin
                w_state_d = StPayload;
                w_cnt_d   = 8'd3;
            end
            StPayload: begin
                if (w_payload_done) begin
`ifdef DSI_SCHED_EOTP_EN
                    w_state_d = StEot;
                    w_cnt_d   = 8'd3;
`else
                    w_state_d = StTrail;
                    w_cnt_d   = TRAIL_LD;
`endif
                end else if (!r_grant_vid) begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
`ifdef DSI_SCHED_EOTP_EN
            StEot: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StTrail;
                    w_cnt_d   = TRAIL_LD;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
`endif
            StTrail: begin
                if (r_cnt == 8'd0) begin
                    w_state_d = StExit;
                end else begin
                    w_cnt_d = r_cnt - 8'd1;
                end
            end
            StExit:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Outputs for the state being entered, so they are registered yet aligned.
    always_comb begin
        w_lp_data_d    = 2'b11;
        w_lp_clk_d     = 2'b00;
        w_hs_data_en_d = 1'b0;
        w_hs_clk_en_d  = 1'b1;
        w_byte_d       = 8'h00;
        w_vid_ready_d  = 1'b0;
        case (w_state_d)
            StIdle: begin
                w_lp_clk_d    = 2'b11;
                w_hs_clk_en_d = 1'b0;
            end
            StLpx:  w_lp_data_d = 2'b01;
            StPrep: w_lp_data_d = 2'b00;
            StZero: begin
                w_lp_data_d    = 2'b00;
                w_hs_data_en_d = 1'b1;
            end
            StSync: begin
                w_lp_data_d    = 2'b00;
                w_hs_data_en_d = 1'b1;
                w_byte_d       = 8'hB8;
            end
            StPayload: begin
                w_lp_data_d    = 2'b00;
                w_hs_data_en_d = 1'b1;
                w_vid_ready_d  = r_grant_vid;
                // Counter runs 3..0, so DI (bits 7:0) goes out first.
                case (w_cnt_d[1:0])
                    2'd3:    w_byte_d = r_cmd[7:0];
                    2'd2:    w_byte_d = r_cmd[15:8];
                    2'd1:    w_byte_d = r_cmd[23:16];
                    default: w_byte_d = r_cmd[31:24];
                endcase
            end
`ifdef DSI_SCHED_EOTP_EN
            StEot: begin
                w_lp_data_d    = 2'b00;
                w_hs_data_en_d = 1'b1;
                case (w_cnt_d[1:0])
                    2'd3:    w_byte_d = 8'h08;
                    2'd0:    w_byte_d = 8'h01;
                    default: w_byte_d = 8'h0F;
                endcase
            end
`endif
            StTrail: begin
                w_lp_data_d    = 2'b00;
                w_hs_data_en_d = 1'b1;
                w_byte_d       = {8{~w_last_byte_d[7]}};
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_byte_clk) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_cnt        <= 8'd0;
            r_grant_vid  <= 1'b0;
            r_last_vid   <= 1'b1;
            r_cmd        <= 32'd0;
            r_last_byte  <= 8'd0;
            r_byte       <= 8'd0;
            r_lp_data    <= 2'b11;
            r_lp_clk     <= 2'b11;
            r_hs_data_en <= 1'b0;
            r_hs_clk_en  <= 1'b0;
            r_vid_ready  <= 1'b0;
            r_underrun   <= 1'b0;
        end else begin
            r_state      <= w_state_d;
            r_cnt        <= w_cnt_d;
            r_last_byte  <= w_last_byte_d;
            r_byte       <= w_byte_d;
            r_lp_data    <= w_lp_data_d;
            r_lp_clk     <= w_lp_clk_d;
            r_hs_data_en <= w_hs_data_en_d;
            r_hs_clk_en  <= w_hs_clk_en_d;
            r_vid_ready  <= w_vid_ready_d;
            if (r_state == StIdle && (w_grant_cmd || w_grant_vid)) begin
                r_grant_vid <= w_grant_vid;
                r_last_vid  <= w_grant_vid;
            end
            if (r_state == StIdle && w_grant_cmd) begin
                r_cmd <= io_bus.cmd_pkt;
            end
            if (w_vid_phase && !io_bus.vid_valid) begin
                r_underrun <= 1'b1;
            end
        end
    end

    // cmd_ready marks the cycle in which cmd_pkt is captured.
    assign io_bus.cmd_ready  = (r_state == StIdle) & w_grant_cmd & ~i_reset;
    assign io_bus.vid_ready  = r_vid_ready;
    assign io_bus.byte_D0    = w_byte_out;
    assign io_bus.hs_data_en = r_hs_data_en;
    assign io_bus.hs_clk_en  = r_hs_clk_en;
    assign io_bus.lp_data    = r_lp_data;
    assign io_bus.lp_clk     = r_lp_clk;
    assign io_bus.underrun   = r_underrun;
endmodule

// File: tb/tb_dsi_lane_scheduler.sv
// Directed testbench for dsi_lane_scheduler: reset state, cmd and video bursts,
// underrun, round-robin arbitration, mid-burst reset and T_ZERO=0.
// Follows DSI_SCHED_EOTP_EN if defined for the build.
module tb_dsi_lane_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    dsi_lane_scheduler_if bus_if ();
    dsi_lane_scheduler_if bus_z ();

    dsi_lane_scheduler dut (
        .i_byte_clk(clk),
        .i_reset   (rst),
        .io_bus    (bus_if)
    );

    dsi_lane_scheduler #(
        .T_ZERO(0)
    ) dut_z (
        .i_byte_clk(clk),
        .i_reset   (rst),
        .io_bus    (bus_z)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Returns once the main DUT sits in IDLE, or ok=0 after the budget.
    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus_if.lp_data == 2'b11 && bus_if.hs_clk_en == 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic wait_vid_ready(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus_if.vid_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.lp_data, bus_if.lp_clk, bus_if.hs_data_en, bus_if.hs_clk_en, bus_if.byte_D0}
            !== {2'b11, 2'b11, 1'b0, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL reset_lanes got=%h exp=%h", {bus_if.lp_data, bus_if.lp_clk,
                     bus_if.hs_data_en, bus_if.hs_clk_en, bus_if.byte_D0}, 14'h3C00);
        end
        n_checks++;
        if ({bus_if.vid_ready, bus_if.cmd_ready, bus_if.underrun} !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_flags got=%b exp=000",
                     {bus_if.vid_ready, bus_if.cmd_ready, bus_if.underrun});
        end
    endtask

    task automatic test_cmd;
        logic [7:0] exp_q[$];
        logic [5:0] obs;
        bit ok;
        exp_q = {8'h00, 8'h00, 8'h00, 8'h00, 8'hB8, 8'h05, 8'h32, 8'h00, 8'h1A};
`ifdef DSI_SCHED_EOTP_EN
        exp_q = {exp_q, 8'h08, 8'h0F, 8'h0F, 8'h01};
`endif
        exp_q = {exp_q, 8'hFF, 8'hFF, 8'hFF};
        bus_if.cmd_pkt   = 32'h1A003205;
        bus_if.cmd_valid = 1'b1;
        #1;
        n_checks++;
        if (bus_if.cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL cmd_ready_grant got=%b exp=1", bus_if.cmd_ready);
        end
        tick();
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_pkt   = 32'h0;
        #1;
        n_checks++;
        if (bus_if.cmd_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL cmd_ready_pulse got=%b exp=0", bus_if.cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            obs = {bus_if.lp_data, bus_if.lp_clk, bus_if.hs_data_en, bus_if.hs_clk_en};
            n_checks++;
            if (obs !== {(i < 2) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b1}) begin
                n_errors++;
                $display("FAIL cmd_lp_entry[%0d] got=%b exp=%b", i, obs,
                         {(i < 2) ? 2'b01 : 2'b00, 2'b00, 1'b0, 1'b1});
            end
            tick();
        end
        foreach (exp_q[i]) begin
            n_checks++;
            if ({bus_if.lp_data, bus_if.hs_data_en, bus_if.byte_D0} !== {2'b00, 1'b1, exp_q[i]})
            begin
                n_errors++;
                $display("FAIL cmd_hs_byte[%0d] got=%h/%b exp=%h/1", i, bus_if.byte_D0,
                         bus_if.hs_data_en, exp_q[i]);
            end
            tick();
        end
        obs = {bus_if.lp_data, bus_if.lp_clk, bus_if.hs_data_en, bus_if.hs_clk_en};
        n_checks++;
        if (obs !== 6'b11_00_0_1) begin
            n_errors++;
            $display("FAIL cmd_exit got=%b exp=110001", obs);
        end
        tick();
        wait_idle(1, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL cmd_back_to_idle got=%b/%b exp=11/0", bus_if.lp_data,
                     bus_if.hs_clk_en);
        end
    endtask

    task automatic test_vid;
        logic [7:0] dat[3];
        logic [7:0] exp_q[$];
        int ready_cnt;
        bit ok;
        dat = '{8'hAA, 8'h55, 8'h80};
`ifdef DSI_SCHED_EOTP_EN
        exp_q = {8'h08, 8'h0F, 8'h0F, 8'h01, 8'hFF, 8'hFF, 8'hFF};
`else
        exp_q = {8'h00, 8'h00, 8'h00};
`endif
        ready_cnt = 0;
        bus_if.vid_req = 1'b1;
        tick();
        bus_if.vid_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (bus_if.vid_ready) ready_cnt++;
            tick();
        end
        n_checks++;
        if ({bus_if.hs_data_en, bus_if.byte_D0} !== {1'b1, 8'hB8}) begin
            n_errors++;
            $display("FAIL vid_sync got=%h exp=b8", bus_if.byte_D0);
        end
        if (bus_if.vid_ready) ready_cnt++;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus_if.vid_valid = 1'b1;
            bus_if.vid_data  = dat[i];
            bus_if.vid_last  = (i == 2);
            #1;
            if (bus_if.vid_ready) ready_cnt++;
            n_checks++;
            if (bus_if.byte_D0 !== dat[i]) begin
                n_errors++;
                $display("FAIL vid_payload[%0d] got=%h exp=%h", i, bus_if.byte_D0, dat[i]);
            end
            tick();
        end
        bus_if.vid_valid = 1'b0;
        bus_if.vid_last  = 1'b0;
        bus_if.vid_data  = 8'h00;
        foreach (exp_q[i]) begin
            if (bus_if.vid_ready) ready_cnt++;
            n_checks++;
            if ({bus_if.hs_data_en, bus_if.byte_D0} !== {1'b1, exp_q[i]}) begin
                n_errors++;
                $display("FAIL vid_tail[%0d] got=%h exp=%h", i, bus_if.byte_D0, exp_q[i]);
            end
            tick();
        end
        wait_idle(4, ok);
        n_checks++;
        if (ready_cnt != 3 || !ok) begin
            n_errors++;
            $display("FAIL vid_ready_count got=%0d idle=%b exp=3 idle=1", ready_cnt, ok);
        end
        n_checks++;
        if (bus_if.underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL vid_no_underrun got=%b exp=0", bus_if.underrun);
        end
    endtask

    task automatic test_underrun;
        bit ok;
        bus_if.vid_req = 1'b1;
        tick();
        bus_if.vid_req = 1'b0;
        wait_vid_ready(40, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL underrun_payload_timeout got=0 exp=1");
        end
        bus_if.vid_valid = 1'b1;
        bus_if.vid_data  = 8'h12;
        tick();
        n_checks++;
        if (bus_if.underrun !== 1'b0) begin
            n_errors++;
            $display("FAIL underrun_early got=%b exp=0", bus_if.underrun);
        end
        bus_if.vid_valid = 1'b0;
        #1;
        n_checks++;
        if (bus_if.byte_D0 !== 8'h00) begin
            n_errors++;
            $display("FAIL underrun_gap_byte got=%h exp=00", bus_if.byte_D0);
        end
        tick();
        bus_if.vid_valid = 1'b1;
        bus_if.vid_data  = 8'h34;
        bus_if.vid_last  = 1'b1;
        #1;
        n_checks++;
        if ({bus_if.underrun, bus_if.byte_D0} !== {1'b1, 8'h34}) begin
            n_errors++;
            $display("FAIL underrun_set got=%b/%h exp=1/34", bus_if.underrun, bus_if.byte_D0);
        end
        tick();
        bus_if.vid_valid = 1'b0;
        bus_if.vid_last  = 1'b0;
        wait_idle(40, ok);
        tick();
        tick();
        n_checks++;
        if (bus_if.underrun !== 1'b1 || !ok) begin
            n_errors++;
            $display("FAIL underrun_sticky got=%b idle=%b exp=1 idle=1", bus_if.underrun, ok);
        end
    endtask

    task automatic test_round_robin;
        bit ok;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus_if.vid_req   = 1'b1;
        bus_if.cmd_valid = 1'b1;
        bus_if.cmd_pkt   = 32'h11223344;
        #1;
        n_checks++;
        if (bus_if.cmd_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL rr_first_cmd got=%b exp=1", bus_if.cmd_ready);
        end
        tick();
        wait_idle(60, ok);
        n_checks++;
        if (bus_if.cmd_ready !== 1'b0 || !ok) begin
            n_errors++;
            $display("FAIL rr_then_vid got=%b idle=%b exp=0 idle=1", bus_if.cmd_ready, ok);
        end
        tick();
        wait_vid_ready(40, ok);
        bus_if.vid_valid = 1'b1;
        bus_if.vid_last  = 1'b1;
        bus_if.vid_data  = 8'h3C;
        #1;
        n_checks++;
        if ({ok, bus_if.byte_D0} !== {1'b1, 8'h3C}) begin
            n_errors++;
            $display("FAIL rr_vid_byte got=%h ready=%b exp=3c ready=1", bus_if.byte_D0, ok);
        end
        tick();
        bus_if.vid_valid = 1'b0;
        bus_if.vid_last  = 1'b0;
        wait_idle(60, ok);
        n_checks++;
        if (bus_if.cmd_ready !== 1'b1 || !ok) begin
            n_errors++;
            $display("FAIL rr_cmd_again got=%b idle=%b exp=1 idle=1", bus_if.cmd_ready, ok);
        end
        tick();
        bus_if.vid_req   = 1'b0;
        bus_if.cmd_valid = 1'b0;
        wait_idle(60, ok);
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL rr_final_idle got=0 exp=1");
        end
    endtask

    task automatic test_reset_mid;
        logic seen_hs;
        bus_if.cmd_pkt   = 32'hDEADBEEF;
        bus_if.cmd_valid = 1'b1;
        tick();
        bus_if.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        n_checks++;
        if ({bus_if.hs_data_en, bus_if.byte_D0} !== {1'b1, 8'h00}) begin
            n_errors++;
            $display("FAIL mid_in_zero got=%b/%h exp=1/00", bus_if.hs_data_en, bus_if.byte_D0);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus_if.lp_data, bus_if.lp_clk, bus_if.hs_data_en, bus_if.hs_clk_en, bus_if.byte_D0}
            !== {2'b11, 2'b11, 1'b0, 1'b0, 8'h00}) begin
            n_errors++;
            $display("FAIL mid_reset_idle got=%b/%b/%b/%b/%h exp=11/11/0/0/00", bus_if.lp_data,
                     bus_if.lp_clk, bus_if.hs_data_en, bus_if.hs_clk_en, bus_if.byte_D0);
        end
        n_checks++;
        if ({bus_if.underrun, bus_if.vid_ready, bus_if.cmd_ready} !== 3'b000) begin
            n_errors++;
            $display("FAIL mid_reset_flags got=%b exp=000",
                     {bus_if.underrun, bus_if.vid_ready, bus_if.cmd_ready});
        end
        seen_hs = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen_hs = seen_hs | bus_if.hs_clk_en | bus_if.hs_data_en;
        end
        n_checks++;
        if (seen_hs !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_no_partial got=%b exp=0", seen_hs);
        end
    endtask

    task automatic test_tzero;
        logic [1:0] lp_exp[4];
        bit ok;
        lp_exp = '{2'b01, 2'b01, 2'b00, 2'b00};
        bus_z.cmd_pkt   = 32'h00000021;
        bus_z.cmd_valid = 1'b1;
        tick();
        bus_z.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({bus_z.lp_data, bus_z.hs_data_en} !== {lp_exp[i], 1'b0}) begin
                n_errors++;
                $display("FAIL tzero_lp[%0d] got=%b/%b exp=%b/0", i, bus_z.lp_data,
                         bus_z.hs_data_en, lp_exp[i]);
            end
            tick();
        end
        n_checks++;
        if ({bus_z.hs_data_en, bus_z.byte_D0} !== {1'b1, 8'h00}) begin
            n_errors++;
            $display("FAIL tzero_zero got=%b/%h exp=1/00", bus_z.hs_data_en, bus_z.byte_D0);
        end
        tick();
        n_checks++;
        if ({bus_z.hs_data_en, bus_z.byte_D0} !== {1'b1, 8'hB8}) begin
            n_errors++;
            $display("FAIL tzero_sync got=%b/%h exp=1/b8", bus_z.hs_data_en, bus_z.byte_D0);
        end
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus_z.lp_data == 2'b11 && bus_z.hs_clk_en == 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_errors++;
            $display("FAIL tzero_idle got=0 exp=1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        bus_if.vid_req   = 1'b0;
        bus_if.vid_valid = 1'b0;
        bus_if.vid_data  = 8'h00;
        bus_if.vid_last  = 1'b0;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd_pkt   = 32'h0;
        bus_z.vid_req    = 1'b0;
        bus_z.vid_valid  = 1'b0;
        bus_z.vid_data   = 8'h00;
        bus_z.vid_last   = 1'b0;
        bus_z.cmd_valid  = 1'b0;
        bus_z.cmd_pkt    = 32'h0;
        test_reset();
        test_cmd();
        tick();
        test_vid();
        tick();
        test_underrun();
        test_round_robin();
        test_reset_mid();
        test_tzero();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/dsi_lane_scheduler.md
DSI_LANE_SCHEDULER -- requirements
Module: dsi_lane_scheduler

Interface
REQ-001 The block SHALL have parameter T_LPX, default 2: byte_clk cycles in the LP-01 state.
REQ-002 The block SHALL have parameter T_PREP, default 2: byte_clk cycles in the LP-00 (HS-prepare) state.
REQ-003 The block SHALL have parameter T_ZERO, default 4: byte_clk cycles of HS-zero (0x00) before the sync byte.
REQ-004 The block SHALL have parameter T_TRAIL, default 3: byte_clk cycles of HS-trail; a value of 0 for any T_* parameter SHALL be treated as 1.
REQ-005 The block SHALL use one clock and a synchronous, active-high reset, with these ports:
- byte_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- vid_req  in  1  video line burst pending
- vid_valid  in  1  vid_data valid
- vid_data  in  8  video payload byte
- vid_last  in  1  final byte of the burst
- vid_ready  out  1  byte accepted this cycle
- cmd_valid  in  1  short packet pending
- cmd_pkt  in  32  {ECC,data1,data0,DI}; DI is sent first
- cmd_ready  out  1  one-cycle capture pulse
- byte_D0  out  8  HS byte to the PHY
- hs_data_en  out  1  data lane in HS
- hs_clk_en  out  1  clock lane in HS
- lp_data  out  2  data lane LP {P,N}
- lp_clk  out  2  clock lane LP {P,N}
- underrun  out  1  sticky video starvation flag

Function
REQ-006 The FSM SHALL have the states IDLE, LPX, PREP, ZERO, SYNC, PAYLOAD, EOT, TRAIL and EXIT.
REQ-007 IDLE: lp_data=11, lp_clk=11, hs_data_en=0, hs_clk_en=0, byte_D0=0x00.
REQ-008 In IDLE, if vid_req or cmd_valid is high, the FSM SHALL grant and go to LPX on the next cycle.
- Grant is round-robin when both are pending: the requester not granted last wins. After reset, cmd wins.
REQ-009 A cmd grant SHALL pulse cmd_ready for exactly the IDLE->LPX cycle and capture cmd_pkt into a 32-bit register.
REQ-010 LPX SHALL last T_LPX cycles with lp_data=01 and lp_clk=00; hs_clk_en SHALL be 1 in every state except IDLE.
REQ-011 PREP SHALL last T_PREP cycles with lp_data=00 and hs_data_en=0.
REQ-012 ZERO SHALL last T_ZERO cycles with hs_data_en=1 and byte_D0=0x00.
- hs_data_en SHALL stay 1 through SYNC, PAYLOAD, EOT and TRAIL; lp_data SHALL be 00 from PREP through TRAIL.
REQ-013 SYNC SHALL last 1 cycle with byte_D0=0xB8.
REQ-014 PAYLOAD for a cmd grant SHALL last exactly 4 cycles, sending cmd_pkt[7:0], [15:8], [23:16], [31:24] in that order.
REQ-015 PAYLOAD for a vid grant:
- vid_ready=1 every PAYLOAD cycle and 0 in all other states.
- If vid_valid=1, byte_D0=vid_data.
- If vid_valid=0, byte_D0=0x00 and underrun is set.
- The state ends after the cycle in which vid_valid&vid_last is sampled.
REQ-016 byte_D0 SHALL be registered: the byte for a state appears in the cycle the FSM is in that state, with no extra pipeline stage.
REQ-017 The block SHALL register the last payload byte sent. TRAIL SHALL last T_TRAIL cycles with byte_D0 = {8{~last_byte[7]}}.
REQ-018 EXIT SHALL last 1 cycle with lp_data=11, hs_data_en=0, hs_clk_en=1 and lp_clk=00, then return to IDLE.
- IDLE lasts at least 1 cycle between bursts.
REQ-019 Requests arriving outside IDLE SHALL be held by the requester; they are not latched. A cmd_valid deasserted before grant is dropped without error.
REQ-020 underrun SHALL clear only on reset.
REQ-021 The phase counters SHALL be 8 bits wide, load (T_x−1) on state entry and advance at 0; no counter wraps.

Reset
REQ-022 On reset high at a clock edge, the FSM SHALL go to IDLE from any state, including mid-burst, with all IDLE outputs of REQ-007 on the next cycle.
REQ-023 Reset SHALL also force vid_ready=0, cmd_ready=0, underrun=0, last-grant=vid (so cmd wins first), and clear the captured cmd and last_byte registers to 0.
REQ-024 The block SHALL not emit a partial packet after reset.

Configuration
REQ-025 With macro DSI_SCHED_EOTP_EN defined, an EOT state SHALL follow PAYLOAD and last 4 cycles sending 0x08, 0x0F, 0x0F, 0x01.
- last_byte for TRAIL SHALL then be 0x01.
REQ-026 Without DSI_SCHED_EOTP_EN, PAYLOAD SHALL go directly to TRAIL and the EOT state logic SHALL be absent.

Verification
REQ-027 Scenario: reset, then cmd_pkt=0x1A003205 with cmd_valid -> cmd_ready pulses 1 cycle; the trace is lp_data 01×2, 00×2, then HS bytes.
- Without EOTP: HS bytes 00×4, B8, 05, 32, 00, 1A, then FF×3; EXIT lp_data=11.
- With EOTP: 08, 0F, 0F, 01 follow 1A, then FF×3; EXIT lp_data=11.
REQ-028 Scenario: vid burst of 3 bytes AA, 55, 80 (last on 80), EOTP off -> B8, AA, 55, 80, then trail 00×3; vid_ready high exactly 3 cycles.
REQ-029 Scenario: vid_req and cmd_valid both high in IDLE after reset -> cmd is served first, then vid, then cmd again if both are still pending.
REQ-030 Scenario: vid_valid=0 for 1 cycle mid-PAYLOAD -> byte_D0=00 that cycle, underrun=1 and stays 1 until reset.
REQ-031 Scenario: reset asserted during ZERO -> next cycle IDLE, lp_data=11, hs_data_en=0, hs_clk_en=0.
REQ-032 Scenario: T_ZERO=0 -> exactly one 0x00 cycle precedes 0xB8.
